// File: rtl/board_rand.sv
// Flood-It board randomizer: fills board RAM with LFSR-derived colours, one cell per clock,
// then holds BOARD_READY until the requester drops INITIALIZE_BOARD.
module board_rand #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       MASTER_CLOCK,
    input  logic       RESET,
    input  logic       INITIALIZE_BOARD,
    input  logic [4:0] final_SIZE,
    input  logic [3:0] final_COLOR_NUM,
    output logic       BOARD_READY,
    output logic       WR_EN,
    output logic [9:0] WR_ADDR,
    output logic [2:0] WR_COLOR,
    output logic [2:0] START_COLOR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_lfsr, w_lfsr_nxt;
    logic [4:0]  r_size, w_size_nxt;
    logic [4:0]  r_row, w_row_nxt;
    logic [4:0]  r_col, w_col_nxt;
    logic [3:0]  r_ncol, w_ncol_nxt, w_ncol_in;
    logic        r_ready, w_ready_nxt;
    logic        r_wr_en, w_wr_en_nxt;
    logic [9:0]  r_addr, w_addr_nxt;
    logic [2:0]  r_color, w_color_nxt;
    logic [2:0]  r_start, w_start_nxt;
    logic [11:0] w_prod;
    logic [2:0]  w_color;
    logic        w_col_wrap;
    logic        w_last;

    // LFSR free-runs in every state so request timing perturbs the board.
    assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // Scale an 8-bit random fraction by N; the result is always below N.
    assign w_prod  = {4'b0000, r_lfsr[7:0]} * {8'h00, r_ncol};
    assign w_color = w_prod[10:8];

    assign w_col_wrap = (r_col == (r_size - 5'd1));
    assign w_last     = w_col_wrap && (r_row == (r_size - 5'd1));

    always_comb begin
        w_ncol_in = final_COLOR_NUM;
        if (final_COLOR_NUM == 4'd0) begin
            w_ncol_in = 4'd1;
        end else if (final_COLOR_NUM > 4'd8) begin
            w_ncol_in = 4'd8;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_size_nxt  = r_size;
        w_ncol_nxt  = r_ncol;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_ready_nxt = 1'b0;
        w_wr_en_nxt = 1'b0;
        w_addr_nxt  = r_addr;
        w_color_nxt = r_color;
        w_start_nxt = r_start;
        case (r_state)
            S_IDLE: begin
                if (INITIALIZE_BOARD) begin
                    w_size_nxt  = final_SIZE;
                    w_ncol_nxt  = w_ncol_in;
                    w_row_nxt   = 5'd0;
                    w_col_nxt   = 5'd0;
                    w_state_nxt = (final_SIZE == 5'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (!INITIALIZE_BOARD) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wr_en_nxt = 1'b1;
                    w_addr_nxt  = {r_row, r_col};
                    w_color_nxt = w_color;
                    if ((r_row == 5'd0) && (r_col == 5'd0)) begin
                        w_start_nxt = w_color;
                    end
                    if (w_col_wrap) begin
                        w_col_nxt = 5'd0;
                        w_row_nxt = r_row + 5'd1;
                    end else begin
                        w_col_nxt = r_col + 5'd1;
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (INITIALIZE_BOARD) begin
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_size  <= 5'd0;
            r_ncol  <= 4'd1;
            r_row   <= 5'd0;
            r_col   <= 5'd0;
            r_ready <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= 10'd0;
            r_color <= 3'd0;
            r_start <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_size  <= w_size_nxt;
            r_ncol  <= w_ncol_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_ready <= w_ready_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_addr  <= w_addr_nxt;
            r_color <= w_color_nxt;
            r_start <= w_start_nxt;
        end
    end

    assign BOARD_READY = r_ready;
    assign WR_EN       = r_wr_en;
    assign WR_ADDR     = r_addr;
    assign WR_COLOR    = r_color;
    assign START_COLOR = r_start;

endmodule

// File: tb/tb_board_rand.sv
// Directed bench for board_rand: expected write addresses are queued at each request and
// popped as writes appear; colours come from an independent LFSR model reset with the DUT.
module tb_board_rand;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [4:0] size = 5'd0;
    logic [3:0] ncol = 4'd0;
    logic       ready;
    logic       wr_en;
    logic [9:0] addr;
    logic [2:0] color;
    logic [2:0] start;

    board_rand #(.LFSR_SEED(SEED)) dut (
        .MASTER_CLOCK    (clk),
        .RESET           (rst),
        .INITIALIZE_BOARD(init),
        .final_SIZE      (size),
        .final_COLOR_NUM (ncol),
        .BOARD_READY     (ready),
        .WR_EN           (wr_en),
        .WR_ADDR         (addr),
        .WR_COLOR        (color),
        .START_COLOR     (start)
    );

    always #5 clk = ~clk;

    // m_prev holds the LFSR value that was current just before the latest edge.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_wr = 0;
    int         cyc = 0;
    int         exp_n = 1;
    logic [9:0] q[$];
    bit         seen[1024];
    logic [2:0] first_col = 3'd0;

    function automatic logic [2:0] model_color(input logic [15:0] l, input int n);
        int prod;
        if (n == 8) return l[7:5];
        prod = int'(l[7:0]) * n;
        return 3'(prod >> 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            n_wr++;
            check("write_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_addr", addr, e);
                check("wr_color", color, model_color(m_prev, exp_n));
                check("color_range", 32'(int'(color) < exp_n), 1);
                check("dup_addr", 32'(seen[addr]), 0);
                seen[addr] = 1'b1;
                if (e == 10'd0) first_col = color;
            end
        end
    endtask

    task automatic start_fill(input int s, input int n);
        size  = 5'(s);
        ncol  = 4'(n);
        exp_n = (n == 0) ? 1 : ((n > 8) ? 8 : n);
        q.delete();
        seen = '{default: 1'b0};
        for (int r = 0; r < s; r++)
            for (int c = 0; c < s; c++)
                q.push_back(10'(r * 32 + c));
        n_wr = 0;
        cyc  = 0;
        init = 1'b1;
    endtask

    task automatic wait_ready(input int s, input int budget);
        do tick(); while (ready !== 1'b1 && cyc < budget);
        check("ready_latency", cyc, s * s + 2);
        check("wr_en_low_at_ready", wr_en, 0);
        check("write_count", n_wr, s * s);
        check("queue_drained", q.size(), 0);
        if (s > 0) check("start_color", start, first_col);
    endtask

    task automatic release_hs();
        repeat (3) begin
            tick();
            check("ready_hold", ready, 1);
            check("no_write_in_done", wr_en, 0);
        end
        init = 1'b0;
        tick();
        check("ready_fall", ready, 0);
        tick();
        check("idle_ready", ready, 0);
        check("idle_wr_en", wr_en, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", addr, 0);
        check("rst_color", color, 0);
        check("rst_start", start, 0);
        rst = 1'b0;
        tick();

        // 2x2, three colours
        start_fill(2, 3);
        wait_ready(2, 20);
        release_hs();

        // largest legal board, eight colours
        start_fill(26, 8);
        wait_ready(26, 800);
        release_hs();

        // zero size skips straight to DONE
        start_fill(0, 3);
        wait_ready(0, 10);
        release_hs();

        // abort after ten writes, then a full restart
        start_fill(14, 5);
        while (n_wr < 10 && cyc < 100) tick();
        check("abort_reached_10", n_wr, 10);
        init = 1'b0;
        q.delete();
        tick();
        check("abort_wr_en_drop", wr_en, 0);
        repeat (5) begin
            tick();
            check("abort_no_ready", ready, 0);
            check("abort_no_write", wr_en, 0);
        end
        check("abort_start_kept", start, first_col);
        start_fill(14, 5);
        wait_ready(14, 300);
        release_hs();

        // asynchronous reset in the middle of a fill
        start_fill(18, 6);
        while (n_wr < 50 && cyc < 200) tick();
        check("rst_mid_reached_50", n_wr, 50);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", ready, 0);
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_addr", addr, 0);
        check("rst_mid_color", color, 0);
        check("rst_mid_start", start, 0);
        init = 1'b0;
        q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // single colour; size change mid-fill is ignored
        start_fill(6, 1);
        while (n_wr < 5 && cyc < 50) tick();
        size = 5'd26;
        wait_ready(6, 100);
        release_hs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
